pkt_arbiter_2to1: RTL and testbench

- Two-input, packet-granular round-robin arbiter sitting directly upstream of the 2:1 output mux in the router datapath.
- Watches the valid and flit-type fields of both input ports and drives the mux one-hot `sel`.
- Locks a grant from HEAD flit to TAIL flit so packets never interleave on the output, and returns per-port ready to the input buffers.

---
 rtl/pkt_arbiter_2to1.sv | 151 +++++++++++++++
 tb/tb_pkt_arbiter_2to1.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_arbiter_2to1.sv
// rtl/pkt_arbiter_2to1.sv - packet-granular 2:1 round-robin arbiter driving the output mux select
// Optional stall timeout: define ARB_TIMEOUT_EN to add the stall counter and the otimeout port.
module pkt_arbiter_2to1 #(
  parameter int DATAW   = 66,
  parameter int TYPEW   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] idata_0,
  input  logic             ivalid_0,
  input  logic [DATAW-1:0] idata_1,
  input  logic             ivalid_1,
  input  logic             iready,
  output logic [1:0]       sel,
  output logic             ordy_0,
  output logic             ordy_1,
  output logic [15:0]      pkt_cnt
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             otimeout
`endif
);

  localparam logic [TYPEW-1:0] TY_HEAD = TYPEW'(1);
  localparam logic [TYPEW-1:0] TY_TAIL = TYPEW'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  logic [TYPEW-1:0] type_0, type_1;
  logic             req_0, req_1, xfer_0, xfer_1;

  // Only the type field steers arbitration; the payload is passed by the mux.
  assign type_0 = idata_0[DATAW-1 -: TYPEW];
  assign type_1 = idata_1[DATAW-1 -: TYPEW];

  logic unused_payload;
  assign unused_payload = ^{idata_0[DATAW-TYPEW-1:0], idata_1[DATAW-TYPEW-1:0]};

  assign req_0  = ivalid_0 && (type_0 == TY_HEAD);
  assign req_1  = ivalid_1 && (type_1 == TY_HEAD);
  assign xfer_0 = ivalid_0 && sel[0] && iready;
  assign xfer_1 = ivalid_1 && sel[1] && iready;

  // Mux select is a pure decode of the registered state, so no input reaches it combinationally.
  always_comb begin
    sel = 2'b00;
    case (state_q)
      LOCK0:   sel = 2'b01;
      LOCK1:   sel = 2'b10;
      default: sel = 2'b00;
    endcase
  end

  assign ordy_0  = sel[0] & iready;
  assign ordy_1  = sel[1] & iready;
  assign pkt_cnt = pkt_cnt_q;

`ifdef ARB_TIMEOUT_EN
  localparam int CNTW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  logic [CNTW-1:0] stall_q, stall_d;
  logic            tout_q, tout_d;

  assign otimeout = tout_q;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // Next-state: grant on HEAD in IDLE, hold the lock until the locked port transfers its TAIL.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_0 && (!req_1 || last_q)) begin
          state_d = LOCK0;
          last_d  = 1'b0;
        end else if (req_1) begin
          state_d = LOCK1;
          last_d  = 1'b1;
        end
      end
      LOCK0: begin
        if (xfer_0 && (type_0 == TY_TAIL)) begin
          state_d   = IDLE;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      LOCK1: begin
        if (xfer_1 && (type_1 == TY_TAIL)) begin
          state_d   = IDLE;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    stall_d = '0;
    tout_d  = 1'b0;
    if (state_q != IDLE) begin
      if (xfer_0 || xfer_1) begin
        stall_d = '0;
      end else if (stall_q == CNTW'(TIMEOUT - 1)) begin
        // A stalled lock is abandoned without counting it as a completed packet.
        state_d   = IDLE;
        pkt_cnt_d = pkt_cnt_q;
        tout_d    = 1'b1;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
`endif
  end

  // State, round-robin pointer and packet counter registers; pointer starts at 1 so port0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      pkt_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Stall counter and one-cycle timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      tout_q  <= tout_d;
    end
  end
`endif

endmodule

// File: tb/tb_pkt_arbiter_2to1.sv
// tb/tb_pkt_arbiter_2to1.sv - self-checking bench for pkt_arbiter_2to1
module tb_pkt_arbiter_2to1;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_DATA = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [65:0] idata_0, idata_1;
  logic        ivalid_0, ivalid_1, iready;
  logic [1:0]  sel;
  logic        ordy_0, ordy_1;
  logic [15:0] pkt_cnt;
`ifdef ARB_TIMEOUT_EN
  logic        otimeout;
`endif

  pkt_arbiter_2to1 dut (
    .clk      (clk),
    .rst      (rst),
    .idata_0  (idata_0),
    .ivalid_0 (ivalid_0),
    .idata_1  (idata_1),
    .ivalid_1 (ivalid_1),
    .iready   (iready),
    .sel      (sel),
    .ordy_0   (ordy_0),
    .ordy_1   (ordy_1),
    .pkt_cnt  (pkt_cnt)
`ifdef ARB_TIMEOUT_EN
    ,
    .otimeout (otimeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    int nflits;
  } exp_t;

  exp_t        exp_q[$];
  logic [65:0] src0[$];
  logic [65:0] src1[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cur_port = -1;
  int          cur_flits = 0;
  int          exp_cnt = 0;
  int          acc0 = 0;
  int          acc1 = 0;
  bit          en0 = 1'b1;
  bit          tail_seen;
  int          tail_port;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [65:0] mk(input logic [1:0] ty, input int n);
    return {ty, 32'hC0DE_0000, 32'(n)};
  endfunction

  task automatic push_pkt(input int port, input int ndata);
    logic [65:0] f;
    for (int i = 0; i < ndata + 2; i++) begin
      f = mk((i == 0) ? T_HEAD : (i == ndata + 1) ? T_TAIL : T_DATA, i);
      if (port == 0) src0.push_back(f);
      else           src1.push_back(f);
    end
  endtask

  task automatic exp_push(input int port, input int nflits);
    exp_t e;
    e.port   = port;
    e.nflits = nflits;
    exp_q.push_back(e);
  endtask

  task automatic drive();
    ivalid_0 = en0 && (src0.size() > 0);
    idata_0  = (src0.size() > 0) ? src0[0] : '0;
    ivalid_1 = (src1.size() > 0);
    idata_1  = (src1.size() > 0) ? src1[0] : '0;
  endtask

  // Scoreboard side: an accepted flit is checked against the packet stream expected on the output.
  task automatic accept(input int port, input logic [65:0] f);
    exp_t e;
    if (cur_port < 0) begin
      check_eq("first_flit_is_head", 32'(f[65:64]), 32'(T_HEAD));
      cur_port  = port;
      cur_flits = 1;
    end else begin
      check_eq("no_interleave", port, cur_port);
      cur_flits++;
    end
    if (f[65:64] == T_TAIL) begin
      check_eq("pkt_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("pkt_port", cur_port, e.port);
        check_eq("pkt_flits", cur_flits, e.nflits);
      end
      exp_cnt++;
      check_eq("pkt_cnt_on_tail", 32'(pkt_cnt), exp_cnt);
      tail_seen = 1'b1;
      tail_port = port;
      cur_port  = -1;
    end
  endtask

  task automatic tick();
    bit a0, a1;
    logic [65:0] f;
    a0 = (ivalid_0 && ordy_0) === 1'b1;
    a1 = (ivalid_1 && ordy_1) === 1'b1;
    @(posedge clk);
    #1;
    if (a0) begin
      acc0++;
      f = src0.pop_front();
      accept(0, f);
    end
    if (a1) begin
      acc1++;
      f = src1.pop_front();
      accept(1, f);
    end
    drive();
  endtask

  task automatic wait_tail(input int port, input int max_cycles);
    int n = 0;
    tail_seen = 1'b0;
    while (!(tail_seen && tail_port == port) && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("tail_arrived", 32'(tail_seen && tail_port == port), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    iready = 1'b1;
    drive();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_sel", 32'(sel), 32'd0);
    check_eq("rst_ordy_0", 32'(ordy_0), 32'd0);
    check_eq("rst_ordy_1", 32'(ordy_1), 32'd0);
    check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);

    // Port1 single packet of 22 flits with the consumer always ready.
    push_pkt(1, 20);
    exp_push(1, 22);
    drive();
    acc1 = 0;
    tick();
    check_eq("t1_sel_after_head", 32'(sel), 32'd2);
    wait_tail(1, 100);
    check_eq("t1_sel_after_tail", 32'(sel), 32'd0);
    check_eq("t1_ordy1_cycles", acc1, 32'd22);
    check_eq("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Simultaneous HEADs: port0 first, one idle bubble, then round-robin.
    push_pkt(0, 3);
    push_pkt(1, 3);
    push_pkt(1, 3);
    exp_push(0, 5);
    exp_push(1, 5);
    exp_push(0, 5);
    exp_push(1, 5);
    drive();
    tick();
    check_eq("t2_tie_port0", 32'(sel), 32'd1);
    wait_tail(0, 50);
    check_eq("t2_bubble", 32'(sel), 32'd0);
    tick();
    check_eq("t2_then_port1", 32'(sel), 32'd2);
    push_pkt(0, 3);
    drive();
    tick();
    check_eq("t2_other_ignored", 32'(sel), 32'd2);
    wait_tail(1, 50);
    check_eq("t2_bubble2", 32'(sel), 32'd0);
    tick();
    check_eq("t2_tie2_port0", 32'(sel), 32'd1);
    wait_tail(0, 50);
    tick();
    check_eq("t2_last_port1", 32'(sel), 32'd2);
    wait_tail(1, 50);
    check_eq("t2_pkt_cnt", 32'(pkt_cnt), 32'd5);

    // Downstream backpressure mid-payload.
    push_pkt(0, 20);
    exp_push(0, 22);
    drive();
    acc0 = 0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    iready = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_sel", 32'(sel), 32'd1);
      check_eq("t3_ordy0_low", 32'(ordy_0), 32'd0);
      tick();
    end
    iready = 1'b1;
    #1;
    wait_tail(0, 100);
    check_eq("t3_flits", acc0, 32'd22);
    check_eq("t3_pkt_cnt", 32'(pkt_cnt), 32'd6);

    // Non-HEAD valid flits in IDLE are never granted.
    for (int t = 0; t < 3; t++) begin
      src1.delete();
      src1.push_back(mk((t == 0) ? T_DATA : (t == 1) ? T_TAIL : T_NONE, t));
      drive();
      for (int i = 0; i < 3; i++) begin
        tick();
        check_eq("t4_sel_idle", 32'(sel), 32'd0);
        check_eq("t4_ordy1_low", 32'(ordy_1), 32'd0);
      end
    end
    src1.delete();
    drive();
    check_eq("t4_pkt_cnt", 32'(pkt_cnt), 32'd6);

    // Reset in the middle of a port0 payload.
    push_pkt(0, 20);
    drive();
    tick();
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_sel_reset", 32'(sel), 32'd0);
    check_eq("t5_ordy0_reset", 32'(ordy_0), 32'd0);
    check_eq("t5_pkt_cnt_reset", 32'(pkt_cnt), 32'd0);
    src0.delete();
    cur_port = -1;
    exp_cnt = 0;
    drive();
    push_pkt(1, 2);
    exp_push(1, 4);
    drive();
    tick();
    check_eq("t5_port1_grant", 32'(sel), 32'd2);
    wait_tail(1, 50);
    check_eq("t5_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Locked port stops sending.
    push_pkt(0, 3);
    drive();
    tick();
    check_eq("t6_locked", 32'(sel), 32'd1);
    en0 = 1'b0;
    drive();
`ifdef ARB_TIMEOUT_EN
    begin
      int pulses = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (otimeout === 1'b1) pulses++;
      end
      check_eq("t6_still_locked", 32'(sel), 32'd1);
      tick();
      if (otimeout === 1'b1) pulses++;
      check_eq("t6_released", 32'(sel), 32'd0);
      check_eq("t6_otimeout_high", 32'(otimeout), 32'd1);
      for (int i = 0; i < 3; i++) begin
        tick();
        if (otimeout === 1'b1) pulses++;
      end
      check_eq("t6_one_pulse", pulses, 32'd1);
      check_eq("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);
      src0.delete();
      en0 = 1'b1;
      drive();
    end
`else
    exp_push(0, 5);
    for (int i = 0; i < 20; i++) tick();
    check_eq("t6_lock_held", 32'(sel), 32'd1);
    en0 = 1'b1;
    drive();
    wait_tail(0, 50);
    check_eq("t6_pkt_cnt", 32'(pkt_cnt), 32'd2);
`endif
    check_eq("exp_q_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
